board_reg_n: RTL and testbench

//  Parametrised N x N game-board register with move validation, turn tracking and lock/full control.

---
 rtl/board_reg_n.sv | 172 +++++++++++++++++
 tb/tb_board_reg_n.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/board_reg_n.sv
// board_reg_n: N x N game-board register with move validation, turn tracking and lock/full control.
// Accept/reject pulses are registered (1-cycle latency); optional undo history enabled by BOARD_UNDO_EN.
module board_reg_n #(
    parameter int N            = 3,
    parameter bit ENFORCE_TURN = 1'b1,
    parameter int HIST_DEPTH   = 4,
    localparam int CELLS       = N * N,
    localparam int IW          = $clog2(CELLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 lock,
    input  logic                 move_valid,
    input  logic                 move_player,
    input  logic [IW-1:0]        move_idx,
    input  logic                 undo,
    output logic [2*CELLS-1:0]   board,
    output logic                 turn,
    output logic [IW:0]          move_count,
    output logic                 move_ready,
    output logic                 move_accept,
    output logic                 move_reject,
    output logic [1:0]           reject_code,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        S_PLAY   = 2'b00,
        S_FULL   = 2'b01,
        S_LOCKED = 2'b10
    } state_t;

    localparam logic [IW:0] CELLS_W = (IW + 1)'(CELLS);

    state_t         state_q, state_d;
    logic [1:0]     cells_q [CELLS];
    logic [IW:0]    cnt_d;
    logic           turn_d;
    logic           acc_d, rej_d;
    logic [1:0]     code_d;
    logic           wr_en;
    logic [IW-1:0]  wr_idx;
    logic [1:0]     wr_val;
    logic           push, pop;
    logic           undo_go;
    logic [IW-1:0]  hist_top;
    logic           idx_ok, cell_occ;

    assign idx_ok     = {1'b0, move_idx} < CELLS_W;
    assign cell_occ   = idx_ok && (cells_q[move_idx] != 2'b00);
    assign move_ready = (state_q == S_PLAY);
    assign state      = state_q;

    for (genvar g = 0; g < CELLS; g++) begin : g_pack
        assign board[2*g +: 2] = cells_q[g];
    end

`ifdef BOARD_UNDO_EN
    localparam int HW = $clog2(HIST_DEPTH + 1);

    // Shift-register LIFO: entry 0 is the most recent move, pushing past depth drops the oldest.
    logic [IW-1:0] hist_q [HIST_DEPTH];
    logic [HW-1:0] hist_cnt;

    assign undo_go  = undo && (hist_cnt != '0) && (state_q != S_LOCKED);
    assign hist_top = hist_q[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_cnt <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else if (clear) begin
            hist_cnt <= '0;
        end else if (push) begin
            hist_q[0] <= move_idx;
            for (int i = 1; i < HIST_DEPTH; i++) hist_q[i] <= hist_q[i-1];
            if (hist_cnt != HW'(HIST_DEPTH)) hist_cnt <= hist_cnt + 1'b1;
        end else if (pop) begin
            for (int i = 0; i < HIST_DEPTH - 1; i++) hist_q[i] <= hist_q[i+1];
            hist_cnt <= hist_cnt - 1'b1;
        end
    end
`else
    logic unused_undo;
    assign undo_go     = 1'b0;
    assign hist_top    = '0;
    assign unused_undo = undo ^ push ^ pop ^ (HIST_DEPTH > 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = move_count;
        turn_d  = turn;
        acc_d   = 1'b0;
        rej_d   = 1'b0;
        code_d  = reject_code;
        wr_en   = 1'b0;
        wr_idx  = move_idx;
        wr_val  = 2'b00;
        push    = 1'b0;
        pop     = 1'b0;
        if (clear) begin
            state_d = S_PLAY;
            cnt_d   = '0;
            turn_d  = 1'b0;
        end else if (undo_go) begin
            wr_en   = 1'b1;
            wr_idx  = hist_top;
            cnt_d   = move_count - 1'b1;
            turn_d  = ~turn;
            pop     = 1'b1;
            state_d = S_PLAY;
        end else begin
            if (lock) state_d = S_LOCKED;
            if (move_valid) begin
                // A move racing a lock is refused as if the board were already frozen.
                if (lock || state_q != S_PLAY) begin
                    rej_d  = 1'b1;
                    code_d = 2'b00;
                end else if (!idx_ok) begin
                    rej_d  = 1'b1;
                    code_d = 2'b10;
                end else if (cell_occ) begin
                    rej_d  = 1'b1;
                    code_d = 2'b01;
                end else if (ENFORCE_TURN && (move_player != turn)) begin
                    rej_d  = 1'b1;
                    code_d = 2'b11;
                end else begin
                    acc_d  = 1'b1;
                    wr_en  = 1'b1;
                    wr_val = move_player ? 2'b10 : 2'b01;
                    cnt_d  = move_count + 1'b1;
                    turn_d = ~move_player;
                    push   = 1'b1;
                    if (move_count + 1'b1 == CELLS_W) state_d = S_FULL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CELLS; i++) cells_q[i] <= 2'b00;
        end else begin
            for (int i = 0; i < CELLS; i++) begin
                if (clear) cells_q[i] <= 2'b00;
                else if (wr_en && wr_idx == IW'(i)) cells_q[i] <= wr_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_PLAY;
            turn        <= 1'b0;
            move_count  <= '0;
            move_accept <= 1'b0;
            move_reject <= 1'b0;
            reject_code <= 2'b00;
        end else begin
            state_q     <= state_d;
            turn        <= turn_d;
            move_count  <= cnt_d;
            move_accept <= acc_d;
            move_reject <= rej_d;
            reject_code <= code_d;
        end
    end

endmodule

// File: tb/tb_board_reg_n.sv
// Bench for board_reg_n (N=3): directed game scenarios plus random moves checked by a scoreboard.
// Honours BOARD_UNDO_EN so the same bench covers both builds.
module tb_board_reg_n;

    localparam int N          = 3;
    localparam int CELLS      = N * N;
    localparam int IW         = $clog2(CELLS);
    localparam int HIST_DEPTH = 4;
`ifdef BOARD_UNDO_EN
    localparam bit UNDO_EN = 1'b1;
`else
    localparam bit UNDO_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                clear = 1'b0, lock = 1'b0, move_valid = 1'b0, move_player = 1'b0, undo = 1'b0;
    logic [IW-1:0]       move_idx = '0;
    logic [2*CELLS-1:0]  board;
    logic                turn, move_ready, move_accept, move_reject;
    logic [IW:0]         move_count;
    logic [1:0]          reject_code, state;

    board_reg_n #(.N(N), .ENFORCE_TURN(1'b1), .HIST_DEPTH(HIST_DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .lock(lock), .move_valid(move_valid),
        .move_player(move_player), .move_idx(move_idx), .undo(undo), .board(board),
        .turn(turn), .move_count(move_count), .move_ready(move_ready),
        .move_accept(move_accept), .move_reject(move_reject),
        .reject_code(reject_code), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cell contents, whose turn, game state and a history of played cells.
    logic [1:0] m_cells [CELLS];
    bit         m_turn;
    int         m_state;
    logic [1:0] m_code;
    int         m_hist[$];
    logic [63:0] expq[$];

    function automatic int m_count();
        int n = 0;
        foreach (m_cells[i]) if (m_cells[i] != 2'b00) n++;
        return n;
    endfunction

    function automatic logic [2*CELLS-1:0] m_board();
        logic [2*CELLS-1:0] b;
        for (int i = 0; i < CELLS; i++) b[2*i +: 2] = m_cells[i];
        return b;
    endfunction

    function automatic logic [63:0] pack(bit a, bit r, logic [1:0] c, logic [2*CELLS-1:0] b,
                                          logic [IW:0] n, bit t, logic [1:0] s, bit rd);
        return 64'({a, r, c, b, n, t, s, rd});
    endfunction

    task automatic m_reset();
        foreach (m_cells[i]) m_cells[i] = 2'b00;
        m_turn = 1'b0; m_state = 0; m_code = 2'b00;
        m_hist.delete();
    endtask

    task automatic model_step(input bit c, u, l, v, p, input int idx, output logic [63:0] e);
        bit acc = 1'b0, rej = 1'b0, was_play;
        int top;
        if (c) begin
            foreach (m_cells[i]) m_cells[i] = 2'b00;
            m_turn = 1'b0; m_state = 0; m_hist.delete();
        end else if (UNDO_EN && u && m_hist.size() > 0 && m_state != 2) begin
            top = m_hist.pop_back();
            m_cells[top] = 2'b00;
            m_turn = !m_turn;
            m_state = 0;
        end else begin
            was_play = (m_state == 0);
            if (l) m_state = 2;
            if (v) begin
                rej = 1'b1;
                if (l || !was_play)               m_code = 2'b00;
                else if (idx >= CELLS)            m_code = 2'b10;
                else if (m_cells[idx] != 2'b00)   m_code = 2'b01;
                else if (p != m_turn)             m_code = 2'b11;
                else begin
                    rej = 1'b0; acc = 1'b1;
                    m_cells[idx] = p ? 2'b10 : 2'b01;
                    m_turn = !p;
                    m_hist.push_back(idx);
                    if (m_hist.size() > HIST_DEPTH) void'(m_hist.pop_front());
                    if (m_count() == CELLS) m_state = 1;
                end
            end
        end
        e = pack(acc, rej, m_code, m_board(), (IW+1)'(m_count()), m_turn, m_state[1:0], m_state == 0);
    endtask

    task automatic step(input bit c, u, l, v, p, input int idx);
        logic [63:0] e;
        @(negedge clk);
        clear = c; undo = u; lock = l; move_valid = v; move_player = p; move_idx = idx[IW-1:0];
        model_step(c, u, l, v, p, idx, e);
        expq.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk); #2;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: one response per driven cycle, compared just after the clock edge.
    initial begin
        logic [63:0] e, got;
        forever begin
            @(posedge clk); #1;
            got = pack(move_accept, move_reject, reject_code, board, move_count, turn, state, move_ready);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("scoreboard", got, e);
            end else begin
                check("stray_pulse", 64'({move_accept, move_reject}), 64'd0);
            end
        end
    end

    initial begin
        bit p;
        m_reset();
        #1;
        check("reset_outputs", 64'({board, move_count, turn, move_accept, move_reject, state}), 64'd0);
        check("reset_ready", 64'(move_ready), 64'd1);
        @(negedge clk); rst = 1'b1;

        // Opening sequence: X@0, O@4, X@8.
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 4);
        step(0, 0, 0, 1, 0, 8);
        settle();
        check("three_moves_board", 64'(board), 64'h10201);
        check("three_moves_count_turn", 64'({move_count, turn}), 64'({5'd3, 1'b1}));

        // Asynchronous reset mid-game, asserted between clock edges.
        idle(); settle(); #1;
        rst = 1'b0; #1;
        check("async_reset_clear", 64'({board, move_count, turn, move_accept, move_reject}), 64'd0);
        check("async_reset_ready", 64'(move_ready), 64'd1);
        m_reset();
        @(negedge clk); rst = 1'b1;

        // Reject codes: occupied, out of range, wrong turn.
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        settle();
        check("reject_occupied", 64'({move_reject, reject_code}), 64'({1'b1, 2'b01}));
        step(0, 0, 0, 1, 1, 9);
        settle();
        check("reject_range", 64'({move_reject, reject_code}), 64'({1'b1, 2'b10}));
        step(0, 0, 0, 1, 0, 1);
        settle();
        check("reject_turn", 64'({move_reject, reject_code}), 64'({1'b1, 2'b11}));

        // Fill the board, then try one more move.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < CELLS; i++) step(0, 0, 0, 1, i[0], i);
        settle();
        check("full_state", 64'({state, move_ready}), 64'({2'b01, 1'b0}));
        step(0, 0, 0, 1, 1, 3);
        settle();
        check("reject_full", 64'({move_reject, reject_code}), 64'({1'b1, 2'b00}));

        // Lock racing a move, then clear.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 1);
        settle();
        check("lock_race", 64'({state, move_reject, reject_code}), 64'({2'b10, 1'b1, 2'b00}));
        step(1, 0, 0, 1, 0, 2);
        settle();
        check("clear_after_lock", 64'({state, board, turn, move_accept, move_reject}), 64'd0);

        // Undo: six moves, five undos.
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, i[0], i);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
        settle();
        check("undo_count", 64'(move_count), UNDO_EN ? 64'd2 : 64'd6);
        check("undo_board", 64'(board), UNDO_EN ? 64'h9 : 64'h999);

        // Random play.
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            p = ($urandom_range(0, 99) < 75) ? m_turn : 1'($urandom_range(0, 1));
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 70, p, $urandom_range(0, 10));
        end
        idle();

        for (int w = 0; w < 10 && expq.size() > 0; w++) @(posedge clk);
        #2;
        check("drain_timeout", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
